spc_write_sequencer: RTL and testbench
======================================

Name: spc_write_sequencer

Overview:
Owns all PC, LR and SP updates for the single-cycle computer and sequences them into the special register file's wr_pc/wr_lr/wr_sp ports. It replaces the racy direct PC drivers with one registered, clocked source.
It keeps authoritative shadow copies of PC/LR/SP, arbitrates fetch advance, branch, call, return and stack push/pop, and emits one-cycle write strobes plus acknowledge handshakes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset/boot
STACK_TOP, 32'h0000_FFFC, SP value at reset; pop limit
SP_LIMIT, 32'h0000_F000, lowest legal SP; push limit

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  blocks fetch advance only
fetch_adv  in  1  level; request PC += 4 this cycle
br_req  in  1  branch request; held until br_ack
br_target  in  32  branch destination, sampled on acceptance
call_req  in  1  call request; held until call_ack
call_target  in  32  call destination, sampled on acceptance
ret_req  in  1  return request; held until ret_ack
push_req  in  1  SP -= 4 request; held until stk_ack
pop_req  in  1  SP += 4 request; held until stk_ack
wr_pc  out  1  PC write strobe to register file
wr_pc_data  out  32  PC write data (= shadow PC)
wr_lr  out  1  LR write strobe
wr_lr_data  out  32  LR write data (= shadow LR)
wr_sp  out  1  SP write strobe
wr_sp_data  out  32  SP write data (= shadow SP)
br_ack, call_ack, ret_ack, stk_ack  out  1 each  one-cycle acknowledges
busy  out  1  high in any state other than IDLE
stk_ovf  out  1  sticky; a push was refused at SP_LIMIT
stk_unf  out  1  sticky; a pop was refused at STACK_TOP

Behaviour:
- All outputs registered. wr_*_data always equals the shadow register. The register file commits on the edge that ends the strobe cycle.
- Reset: applied on a rising clk with reset=1. Shadow PC=RESET_PC, LR=0, SP=STACK_TOP; all strobes, acks, stk_ovf and stk_unf = 0; state=BOOT. Reset during any state abandons the operation and issues no ack.
- States: BOOT, IDLE, CALL_PC, ACK.
- BOOT: one cycle. Next edge sets wr_pc=wr_lr=wr_sp=1 (initialises the file) and goes to IDLE.
- IDLE accepts at most one request per edge. Priority: ret > call > br > push/pop > fetch_adv.
- ret: PC<=LR, wr_pc=1, ret_ack=1 next cycle; ->ACK.
- call: LR<=PC+4, wr_lr=1, target latched; ->CALL_PC. Next edge: PC<=latched target, wr_pc=1, call_ack=1; ->ACK. Call latency is 2 cycles to ack.
- br: PC<=br_target, wr_pc=1, br_ack=1; ->ACK.
- push: if SP==SP_LIMIT, SP unchanged, no wr_sp, stk_ovf<=1; else SP<=SP-4, wr_sp=1. stk_ack=1 either way; ->ACK.
- pop: mirror of push against STACK_TOP (SP+4, stk_unf).
- push and pop together: SP unchanged, no wr_sp, stk_ack=1, no flag; ->ACK.
- fetch_adv with no control request and stall=0: PC<=PC+4, wr_pc=1; stays in IDLE. Sustains 1 advance per cycle.
- ACK: acks and strobes pulse exactly one cycle. No request is accepted and fetch_adv is ignored (prevents double-accept of still-held req). Next edge ->IDLE.
- Strobes/acks deassert on the edge after their cycle unless re-asserted by a new IDLE acceptance.
- Arithmetic is unsigned 32-bit modulo 2^32 (PC 32'hFFFF_FFFC+4 = 0). No alignment checking.
- Requests in BOOT/CALL_PC/ACK are held by the requester and served on a later IDLE edge.

Test Plan:
- Reset, release -> BOOT cycle then wr_pc/wr_lr/wr_sp=1 with data 0/0/FFFC; busy=1 in BOOT, 0 after.
- fetch_adv=1 for 3 cycles from PC=0 -> wr_pc each cycle with data 4, 8, C; stall=1 mid-run -> PC holds, no wr_pc.
- At PC=0x100, call_req target 0x400 -> cycle1 wr_lr data 0x104; cycle2 wr_pc data 0x400 + call_ack; then ret_req -> wr_pc 0x104 + ret_ack.
- ret_req, call_req, br_req and fetch_adv in the same cycle -> only ret served. call served after ACK, then br; PC never advances by 4 during this.
- Push until SP=0xF000, push again -> no wr_sp, stk_ack=1, stk_ovf=1 stays until reset. Pop at FFFC -> stk_unf=1. Push+pop together -> stk_ack, SP unchanged.
- reset=1 in CALL_PC -> no call_ack, PC=RESET_PC, state BOOT next cycle.

Source files
------------

// File: rtl/spc_write_sequencer.sv
// Single registered source for PC/LR/SP updates: arbitrates fetch, branch, call,
// return and stack push/pop into one-cycle register-file write strobes plus acks.
module spc_write_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] STACK_TOP = 32'h0000_FFFC,
  parameter logic [31:0] SP_LIMIT  = 32'h0000_F000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        fetch_adv,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        call_req,
  input  logic [31:0] call_target,
  input  logic        ret_req,
  input  logic        push_req,
  input  logic        pop_req,
  output logic        wr_pc,
  output logic [31:0] wr_pc_data,
  output logic        wr_lr,
  output logic [31:0] wr_lr_data,
  output logic        wr_sp,
  output logic [31:0] wr_sp_data,
  output logic        br_ack,
  output logic        call_ack,
  output logic        ret_ack,
  output logic        stk_ack,
  output logic        busy,
  output logic        stk_ovf,
  output logic        stk_unf
);

  localparam int unsigned W = 32;
  localparam logic [W-1:0] WORD = W'(4);

  typedef enum logic [1:0] {BOOT, IDLE, CALL_PC, ACK} state_t;

  state_t       state;
  logic [W-1:0] call_tgt;

  // The wr_*_data registers are the shadow PC/LR/SP themselves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      wr_pc_data <= RESET_PC;
      wr_lr_data <= '0;
      wr_sp_data <= STACK_TOP;
      call_tgt   <= '0;
      wr_pc      <= 1'b0;
      wr_lr      <= 1'b0;
      wr_sp      <= 1'b0;
      br_ack     <= 1'b0;
      call_ack   <= 1'b0;
      ret_ack    <= 1'b0;
      stk_ack    <= 1'b0;
      busy       <= 1'b1;
      stk_ovf    <= 1'b0;
      stk_unf    <= 1'b0;
    end else begin
      wr_pc    <= 1'b0;
      wr_lr    <= 1'b0;
      wr_sp    <= 1'b0;
      br_ack   <= 1'b0;
      call_ack <= 1'b0;
      ret_ack  <= 1'b0;
      stk_ack  <= 1'b0;
      unique case (state)
        BOOT: begin
          wr_pc <= 1'b1;
          wr_lr <= 1'b1;
          wr_sp <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        CALL_PC: begin
          wr_pc_data <= call_tgt;
          wr_pc      <= 1'b1;
          call_ack   <= 1'b1;
          state      <= ACK;
        end
        // Requesters still hold their req here; ignoring them avoids double accept.
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        IDLE: begin
          if (ret_req) begin
            wr_pc_data <= wr_lr_data;
            wr_pc      <= 1'b1;
            ret_ack    <= 1'b1;
            state      <= ACK;
            busy       <= 1'b1;
          end else if (call_req) begin
            wr_lr_data <= wr_pc_data + WORD;
            wr_lr      <= 1'b1;
            call_tgt   <= call_target;
            state      <= CALL_PC;
            busy       <= 1'b1;
          end else if (br_req) begin
            wr_pc_data <= br_target;
            wr_pc      <= 1'b1;
            br_ack     <= 1'b1;
            state      <= ACK;
            busy       <= 1'b1;
          end else if (push_req || pop_req) begin
            stk_ack <= 1'b1;
            state   <= ACK;
            busy    <= 1'b1;
            if (push_req && !pop_req) begin
              if (wr_sp_data == SP_LIMIT) begin
                stk_ovf <= 1'b1;
              end else begin
                wr_sp_data <= wr_sp_data - WORD;
                wr_sp      <= 1'b1;
              end
            end else if (pop_req && !push_req) begin
              if (wr_sp_data == STACK_TOP) begin
                stk_unf <= 1'b1;
              end else begin
                wr_sp_data <= wr_sp_data + WORD;
                wr_sp      <= 1'b1;
              end
            end
          end else if (fetch_adv && !stall) begin
            wr_pc_data <= wr_pc_data + WORD;
            wr_pc      <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_spc_write_sequencer.sv
// Directed plus randomized checks of spc_write_sequencer against a cycle-level
// behavioural model of the PC/LR/SP rules.
module tb_spc_write_sequencer;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] STACK_TOP = 32'h0000_FFFC;
  localparam logic [31:0] SP_LIMIT  = 32'h0000_F000;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_adv, br_req, call_req, ret_req, push_req, pop_req;
  logic [31:0] br_target, call_target;
  logic        wr_pc, wr_lr, wr_sp, br_ack, call_ack, ret_ack, stk_ack, busy, stk_ovf, stk_unf;
  logic [31:0] wr_pc_data, wr_lr_data, wr_sp_data;

  int n_tests = 0;
  int n_fail  = 0;

  spc_write_sequencer #(.RESET_PC(RESET_PC), .STACK_TOP(STACK_TOP), .SP_LIMIT(SP_LIMIT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .fetch_adv(fetch_adv),
    .br_req(br_req), .br_target(br_target), .call_req(call_req), .call_target(call_target),
    .ret_req(ret_req), .push_req(push_req), .pop_req(pop_req),
    .wr_pc(wr_pc), .wr_pc_data(wr_pc_data), .wr_lr(wr_lr), .wr_lr_data(wr_lr_data),
    .wr_sp(wr_sp), .wr_sp_data(wr_sp_data), .br_ack(br_ack), .call_ack(call_ack),
    .ret_ack(ret_ack), .stk_ack(stk_ack), .busy(busy), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural values plus "cycles owed" bookkeeping.
  logic [31:0] m_pc, m_lr, m_sp, m_tgt;
  bit m_boot, m_callp, m_ackp, m_ovf, m_unf;
  bit e_wpc, e_wlr, e_wsp, e_bra, e_ca, e_ra, e_sa, e_busy;

  task automatic model_edge();
    {e_wpc, e_wlr, e_wsp, e_bra, e_ca, e_ra, e_sa} = '0;
    if (reset) begin
      m_pc = RESET_PC; m_lr = 32'h0; m_sp = STACK_TOP;
      m_ovf = 0; m_unf = 0; m_boot = 1; m_callp = 0; m_ackp = 0; e_busy = 1;
    end else if (m_boot) begin
      e_wpc = 1; e_wlr = 1; e_wsp = 1; m_boot = 0; e_busy = 0;
    end else if (m_callp) begin
      m_pc = m_tgt; e_wpc = 1; e_ca = 1; m_callp = 0; m_ackp = 1; e_busy = 1;
    end else if (m_ackp) begin
      m_ackp = 0; e_busy = 0;
    end else if (ret_req) begin
      m_pc = m_lr; e_wpc = 1; e_ra = 1; m_ackp = 1; e_busy = 1;
    end else if (call_req) begin
      m_lr = m_pc + 32'd4; e_wlr = 1; m_tgt = call_target; m_callp = 1; e_busy = 1;
    end else if (br_req) begin
      m_pc = br_target; e_wpc = 1; e_bra = 1; m_ackp = 1; e_busy = 1;
    end else if (push_req || pop_req) begin
      e_sa = 1; m_ackp = 1; e_busy = 1;
      if (push_req && !pop_req) begin
        if (m_sp == SP_LIMIT) m_ovf = 1;
        else begin m_sp = m_sp - 32'd4; e_wsp = 1; end
      end else if (pop_req && !push_req) begin
        if (m_sp == STACK_TOP) m_unf = 1;
        else begin m_sp = m_sp + 32'd4; e_wsp = 1; end
      end
    end else if (fetch_adv && !stall) begin
      m_pc = m_pc + 32'd4; e_wpc = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk1("wr_pc", wr_pc, e_wpc);   chk("wr_pc_data", wr_pc_data, m_pc);
    chk1("wr_lr", wr_lr, e_wlr);   chk("wr_lr_data", wr_lr_data, m_lr);
    chk1("wr_sp", wr_sp, e_wsp);   chk("wr_sp_data", wr_sp_data, m_sp);
    chk1("br_ack", br_ack, e_bra); chk1("call_ack", call_ack, e_ca);
    chk1("ret_ack", ret_ack, e_ra); chk1("stk_ack", stk_ack, e_sa);
    chk1("busy", busy, e_busy);    chk1("stk_ovf", stk_ovf, m_ovf);
    chk1("stk_unf", stk_unf, m_unf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; fetch_adv = 0; br_req = 0; call_req = 0; ret_req = 0;
    push_req = 0; pop_req = 0; br_target = 32'h0; call_target = 32'h0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    tick(); tick();
    chk1("reset_busy", busy, 1'b1);
    chk1("reset_wr_pc", wr_pc, 1'b0);
    reset = 0;
    tick();
    chk1("boot_wr_pc", wr_pc, 1'b1); chk1("boot_wr_lr", wr_lr, 1'b1); chk1("boot_wr_sp", wr_sp, 1'b1);
    chk("boot_pc", wr_pc_data, 32'h0); chk("boot_lr", wr_lr_data, 32'h0);
    chk("boot_sp", wr_sp_data, 32'h0000_FFFC); chk1("boot_busy", busy, 1'b0);

    fetch_adv = 1;
    tick(); chk("fetch1", wr_pc_data, 32'h4);
    tick(); chk("fetch2", wr_pc_data, 32'h8);
    tick(); chk("fetch3", wr_pc_data, 32'hC);
    stall = 1;
    tick(); chk1("stall_no_wr", wr_pc, 1'b0); chk("stall_pc", wr_pc_data, 32'hC);
    stall = 0; fetch_adv = 0;

    br_req = 1; br_target = 32'h100;
    tick(); chk1("br_ack", br_ack, 1'b1); chk("br_pc", wr_pc_data, 32'h100);
    br_req = 0;
    tick();
    call_req = 1; call_target = 32'h400;
    tick(); chk1("call_wr_lr", wr_lr, 1'b1); chk("call_lr", wr_lr_data, 32'h104);
    chk1("call_no_ack_yet", call_ack, 1'b0);
    tick(); chk1("call_ack", call_ack, 1'b1); chk("call_pc", wr_pc_data, 32'h400);
    call_req = 0;
    tick();
    ret_req = 1;
    tick(); chk1("ret_ack", ret_ack, 1'b1); chk("ret_pc", wr_pc_data, 32'h104);
    ret_req = 0;
    tick();

    // Simultaneous ret/call/br/fetch: served strictly one at a time by priority.
    ret_req = 1; call_req = 1; call_target = 32'h800; br_req = 1; br_target = 32'h900; fetch_adv = 1;
    tick(); chk1("prio_ret", ret_ack, 1'b1); chk1("prio_no_lr", wr_lr, 1'b0);
    ret_req = 0;
    tick(); chk("prio_ack_hold", wr_pc_data, 32'h104);
    tick(); chk("prio_call_lr", wr_lr_data, 32'h108);
    tick(); chk("prio_call_pc", wr_pc_data, 32'h800);
    call_req = 0;
    tick();
    tick(); chk1("prio_br", br_ack, 1'b1); chk("prio_br_pc", wr_pc_data, 32'h900);
    br_req = 0;
    tick(); chk("prio_after", wr_pc_data, 32'h900);
    fetch_adv = 0;

    // PC wraps modulo 2^32.
    br_req = 1; br_target = 32'hFFFF_FFFC;
    tick(); br_req = 0; tick();
    fetch_adv = 1;
    tick(); chk("pc_wrap", wr_pc_data, 32'h0);
    fetch_adv = 0;

    push_req = 1;
    repeat (2046) tick();
    chk("sp_at_limit", wr_sp_data, SP_LIMIT);
    tick(); chk1("ovf_ack", stk_ack, 1'b1); chk1("ovf_no_wr", wr_sp, 1'b0); chk1("ovf_flag", stk_ovf, 1'b1);
    push_req = 0;
    tick();
    push_req = 1; pop_req = 1;
    tick(); chk1("pp_ack", stk_ack, 1'b1); chk1("pp_no_wr", wr_sp, 1'b0); chk("pp_sp", wr_sp_data, SP_LIMIT);
    push_req = 0; pop_req = 0;
    repeat (3) tick();
    chk1("ovf_sticky", stk_ovf, 1'b1);

    // Reset while in CALL_PC abandons the call.
    call_req = 1; call_target = 32'h40;
    tick();
    reset = 1; call_req = 0;
    tick(); chk1("rst_no_call_ack", call_ack, 1'b0); chk("rst_pc", wr_pc_data, RESET_PC);
    chk1("rst_busy", busy, 1'b1); chk1("rst_ovf_clr", stk_ovf, 1'b0);
    reset = 0;
    tick(); chk1("reboot_wr_pc", wr_pc, 1'b1);

    pop_req = 1;
    tick(); chk1("unf_ack", stk_ack, 1'b1); chk1("unf_flag", stk_unf, 1'b1); chk1("unf_no_wr", wr_sp, 1'b0);
    pop_req = 0;
    tick();

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      fetch_adv   = ($urandom_range(0, 3) != 0);
      ret_req     = ($urandom_range(0, 9) == 0);
      call_req    = ($urandom_range(0, 9) == 0);
      br_req      = ($urandom_range(0, 9) == 0);
      push_req    = ($urandom_range(0, 5) == 0);
      pop_req     = ($urandom_range(0, 5) == 0);
      br_target   = $urandom;
      call_target = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
